// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

   localparam int SERIAL_ADDER_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell used as the serial adder's arithmetic core.
// Pure combinational: sum and carry-out of a, b and carry-in c.
module full_ad (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   logic w_p;

   assign w_p = a ^ b;
   assign s   = w_p ^ c;
   assign co  = (a & b) | (c & w_p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per cycle, LSB first, through one full_ad.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SERIAL_ADDER_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             cout,
   output logic             ovf
`else
   output logic             cout
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             w_s;
   logic             w_co;
   logic             w_last;
   logic             w_busy;
   logic             w_done;

   full_ad u_fa (
      .a  (r_a[0]),
      .b  (r_b[0]),
      .c  (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   assign w_last = (r_cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = SHIFT;
         SHIFT:   if (w_last) w_next = FINISH;
         FINISH:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         SHIFT:   w_busy = 1'b1;
         FINISH: begin
            w_busy = 1'b1;
            w_done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_sum   <= '0;
               end
            end
            SHIFT: begin
               // Sum bits enter at the MSB so bit 0 lands at the LSB last.
               r_sum   <= {w_s, r_sum[WIDTH-1:1]};
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_carry <= w_co;
               r_cnt   <= r_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic r_ovf;

   // On the MSB cycle r_carry is the carry into the MSB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_ovf <= 1'b0;
      end else if (r_state == SHIFT && w_last) begin
         r_ovf <= r_carry ^ w_co;
      end
   end

   assign ovf = r_ovf;
`endif

   assign busy = w_busy;
   assign done = w_done;
   assign sum  = r_sum;
   assign cout = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
// Define SERIAL_ADDER_OVF_EN to also check the overflow output.
module tb_serial_adder;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf;
`endif

   int n_pass;
   int n_tot;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
      .cout  (cout),
      .ovf   (ovf)
`else
      .cout  (cout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_add(input string tag, input logic [7:0] ia,
                         input logic [7:0] ib, input logic ic,
                         input logic [7:0] es, input logic ec,
                         input logic eo);
      int dcyc;
      int nbusy;
      dcyc  = 0;
      nbusy = 0;
      @(negedge clk);
      a     = ia;
      b     = ib;
      cin   = ic;
      start = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (cyc == 1) start = 1'b0;
         if (busy) nbusy++;
         if (done) begin
            dcyc = cyc;
            break;
         end
      end
      chk({tag, " done_cycle"}, dcyc, 9);
      chk({tag, " busy_cycles"}, nbusy, 9);
      chk({tag, " sum"}, {24'd0, sum}, {24'd0, es});
      chk({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
`ifdef SERIAL_ADDER_OVF_EN
      chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
      if (eo) begin end
`endif
      @(negedge clk);
      chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, " idle_done"}, {31'd0, done}, 32'd0);
      chk({tag, " held_sum"}, {24'd0, sum}, {24'd0, es});
      chk({tag, " held_cout"}, {31'd0, cout}, {31'd0, ec});
   endtask

   initial begin
      int ndone;
      int d1;
      int d2;
      int d3;
      n_pass = 0;
      n_tot  = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      cin    = 1'b0;

      // Reset state, with start asserted to confirm reset priority.
      @(negedge clk);
      start = 1'b1;
      a     = 8'hAA;
      b     = 8'h55;
      @(negedge clk);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst sum", {24'd0, sum}, 32'd0);
      chk("rst cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("rst ovf", {31'd0, ovf}, 32'd0);
`endif
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst busy", {31'd0, busy}, 32'd0);

      do_add("add5a25", 8'h5A, 8'h25, 1'b0, 8'h7F, 1'b0, 1'b0);
      do_add("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      do_add("addffff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      do_add("ovf7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      do_add("ovf80ff", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);

      // Start during SHIFT with different operands must be ignored.
      @(negedge clk);
      a     = 8'h12;
      b     = 8'h34;
      cin   = 1'b0;
      start = 1'b1;
      d1    = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (cyc >= 3 && cyc <= 5) begin
            start = 1'b1;
            a     = 8'hFF;
            b     = 8'hFF;
            cin   = 1'b1;
         end
         if (done) begin
            d1 = cyc;
            break;
         end
      end
      start = 1'b0;
      chk("ign done_cycle", d1, 9);
      chk("ign sum", {24'd0, sum}, 32'h46);
      chk("ign cout", {31'd0, cout}, 32'd0);
      @(negedge clk);
      chk("ign idle_busy", {31'd0, busy}, 32'd0);

      // Reset pulse at SHIFT cycle 4 aborts with no done.
      @(negedge clk);
      a     = 8'h5A;
      b     = 8'h25;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      chk("abort sum", {24'd0, sum}, 32'd0);
      chk("abort cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("abort ovf", {31'd0, ovf}, 32'd0);
`endif
      ndone = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort no_done", ndone, 0);
      do_add("after_abort", 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0);

      // Start held high for 30 cycles: back-to-back additions.
      @(negedge clk);
      a     = 8'h10;
      b     = 8'h20;
      cin   = 1'b0;
      start = 1'b1;
      ndone = 0;
      d1    = 0;
      d2    = 0;
      d3    = 0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (ndone == 1) d1 = cyc;
            if (ndone == 2) d2 = cyc;
            if (ndone == 3) d3 = cyc;
            chk("b2b sum", {24'd0, sum}, 32'h30);
         end
         if (cyc == 10) chk("b2b gap_idle", {31'd0, busy}, 32'd0);
      end
      start = 1'b0;
      chk("b2b count", ndone, 3);
      chk("b2b first", d1, 9);
      chk("b2b gap12", d2 - d1, 10);
      chk("b2b gap23", d3 - d2, 10);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
